// File: rtl/ad7606_responder_pkg.sv
// Shared definitions for the AD7606 serial-mode device model.
package ad7606_responder_pkg;

  localparam int unsigned N_CH        = 8;
  localparam int unsigned CH_PER_LINE = 4;
  localparam int unsigned CH_IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_STBY = 2'd0,
    ST_WAKE = 2'd1,
    ST_IDLE = 2'd2,
    ST_CONV = 2'd3
  } state_t;

  function automatic logic rose(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic fell(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

endpackage

// File: rtl/ad7606_responder_serializer.sv
// Two-line serial shifter: loads on cs_n fall, shifts on sclk rise, clears while deselected.
module ad7606_responder_serializer
  import ad7606_responder_pkg::*;
#(
  parameter int unsigned LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic [LINE_W-1:0] load_a,
  input  logic [LINE_W-1:0] load_b,
  output logic              douta,
  output logic              doutb,
  output logic              frstdata,
  output logic              dout_en,
  output logic              cs_fall_c,
  output logic              sclk_edge_c
);

  localparam int unsigned CNT_W     = $clog2(LINE_W + 1);
  localparam int unsigned WORD_BITS = LINE_W / CH_PER_LINE;

  logic              cs_n_q;
  logic              sclk_q;
  logic              sclk_rise_c;
  logic [LINE_W-1:0] shift_a;
  logic [LINE_W-1:0] shift_b;
  logic [CNT_W-1:0]  rise_cnt;

  // Pin history follows the inputs even in reset so no phantom edge appears on release.
  always_ff @(posedge clk) begin
    cs_n_q <= cs_n;
    sclk_q <= sclk;
  end

  assign cs_fall_c   = fell(cs_n, cs_n_q);
  assign sclk_rise_c = rose(sclk, sclk_q);
  assign sclk_edge_c = sclk ^ sclk_q;

  // Load/shift registers; deselect clears them so the lines idle at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a  <= '0;
      shift_b  <= '0;
      rise_cnt <= '0;
      frstdata <= 1'b0;
      dout_en  <= 1'b0;
    end else begin
      dout_en <= ~cs_n;
      if (cs_n) begin
        shift_a  <= '0;
        shift_b  <= '0;
        rise_cnt <= '0;
        frstdata <= 1'b0;
      end else if (cs_fall_c) begin
        shift_a  <= load_a;
        shift_b  <= load_b;
        rise_cnt <= '0;
        frstdata <= 1'b1;
      end else if (sclk_rise_c) begin
        shift_a <= {shift_a[LINE_W-2:0], 1'b0};
        shift_b <= {shift_b[LINE_W-2:0], 1'b0};
        if (rise_cnt != CNT_W'(LINE_W)) begin
          rise_cnt <= rise_cnt + CNT_W'(1);
        end
        if (rise_cnt == CNT_W'(WORD_BITS - 1)) begin
          frstdata <= 1'b0;
        end
      end
    end
  end

  assign douta = shift_a[LINE_W-1];
  assign doutb = shift_b[LINE_W-1];

endmodule

// File: rtl/ad7606_responder.sv
// Device-side AD7606 model: standby/wake/convert FSM, result generation, protocol checking.
module ad7606_responder
  import ad7606_responder_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 120,
  parameter int unsigned WAKE_CYCLES = 60,
  parameter int unsigned DATA_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stby,
  input  logic convst,
  input  logic cs_n,
  input  logic sclk,
  output logic busy,
  output logic frstdata,
  output logic douta,
  output logic doutb,
  output logic dout_en,
  output logic viol
);

  localparam int unsigned LINE_W     = CH_PER_LINE * DATA_W;
  localparam int unsigned CONV_CNT_W = DATA_W - CH_IDX_W;
  localparam int unsigned MAX_CYC    = (CONV_CYCLES > WAKE_CYCLES) ? CONV_CYCLES : WAKE_CYCLES;
  localparam int unsigned CYC_W      = $clog2(MAX_CYC + 1);

  state_t                  state;
  logic [CYC_W-1:0]        cyc_cnt;
  logic [CONV_CNT_W-1:0]   conv_cnt;
  logic [DATA_W-1:0]       result [N_CH];
  logic                    convst_q;
  logic                    convst_rise_c;
  logic                    cs_fall_c;
  logic                    sclk_edge_c;
  logic [LINE_W-1:0]       line_a;
  logic [LINE_W-1:0]       line_b;

  // convst history tracks the pin through reset to avoid a false start edge.
  always_ff @(posedge clk) begin
    convst_q <= convst;
  end

  assign convst_rise_c = rose(convst, convst_q);

  // V1..V4 feed line A, V5..V8 line B, lowest channel in the MSBs.
  for (genvar g = 0; g < CH_PER_LINE; g++) begin : g_line
    assign line_a[LINE_W-1-g*DATA_W -: DATA_W] = result[g];
    assign line_b[LINE_W-1-g*DATA_W -: DATA_W] = result[g+CH_PER_LINE];
  end

  // Power/convert FSM; dropping stby aborts everything but keeps results and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_STBY;
      cyc_cnt  <= '0;
      busy     <= 1'b0;
      conv_cnt <= '0;
      for (int k = 0; k < N_CH; k++) begin
        result[k] <= '0;
      end
    end else if (!stby) begin
      state <= ST_STBY;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_STBY: begin
          state   <= ST_WAKE;
          cyc_cnt <= '0;
        end
        ST_WAKE: begin
          if (cyc_cnt == CYC_W'(WAKE_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        ST_IDLE: begin
          if (convst_rise_c) begin
            state   <= ST_CONV;
            busy    <= 1'b1;
            cyc_cnt <= '0;
          end
        end
        ST_CONV: begin
          if (cyc_cnt == CYC_W'(CONV_CYCLES - 1)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            conv_cnt <= conv_cnt + CONV_CNT_W'(1);
            for (int k = 0; k < N_CH; k++) begin
              result[k] <= {conv_cnt, CH_IDX_W'(k)};
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        default: state <= ST_STBY;
      endcase
    end
  end

  // One-cycle violation flag; a convst rise racing stby=0 counts as ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol <= 1'b0;
    end else begin
      viol <= (convst_rise_c && (state != ST_IDLE || !stby))
           || (sclk_edge_c && cs_n)
           || (cs_fall_c && state == ST_STBY);
    end
  end

  ad7606_responder_serializer #(
    .LINE_W (LINE_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .load_a      (line_a),
    .load_b      (line_b),
    .douta       (douta),
    .doutb       (doutb),
    .frstdata    (frstdata),
    .dout_en     (dout_en),
    .cs_fall_c   (cs_fall_c),
    .sclk_edge_c (sclk_edge_c)
  );

endmodule

// File: tb/tb_ad7606_responder.sv
// Directed bench for ad7606_responder; all inputs change and outputs are sampled on negedge.
module tb_ad7606_responder;

  logic clk;
  logic rst;
  logic stby;
  logic convst;
  logic cs_n;
  logic sclk;
  logic busy;
  logic frstdata;
  logic douta;
  logic doutb;
  logic dout_en;
  logic viol;

  int n_vec;
  int n_err;

  logic [63:0] rd_a;
  logic [63:0] rd_b;
  logic [63:0] rd_f;

  ad7606_responder #(
    .CONV_CYCLES (120),
    .WAKE_CYCLES (60),
    .DATA_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stby     (stby),
    .convst   (convst),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .busy     (busy),
    .frstdata (frstdata),
    .douta    (douta),
    .doutb    (doutb),
    .dout_en  (dout_en),
    .viol     (viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sclk idles high: sample on each low phase, then rise to advance.
  task automatic read_frame(output logic [63:0] a, output logic [63:0] b, output logic [63:0] f);
    cs_n = 1'b0;
    step(3);
    chk1("rd_dout_en", dout_en, 1'b1);
    a = '0;
    b = '0;
    f = '0;
    for (int i = 0; i < 64; i++) begin
      sclk = 1'b0;
      step(3);
      a[63-i] = douta;
      b[63-i] = doutb;
      f[63-i] = frstdata;
      sclk = 1'b1;
      step(3);
    end
  endtask

  task automatic end_frame();
    chk1("tail_douta", douta, 1'b0);
    chk1("tail_doutb", doutb, 1'b0);
    cs_n = 1'b1;
    step(3);
    chk1("end_dout_en", dout_en, 1'b0);
  endtask

  task automatic do_conv();
    convst = 1'b1;
    step(1);
    convst = 1'b0;
    step(125);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    stby   = 1'b0;
    convst = 1'b0;
    cs_n   = 1'b1;
    sclk   = 1'b1;

    // Reset and standby
    step(5);
    rst = 1'b0;
    step(1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_frst", frstdata, 1'b0);
    chk1("rst_douta", douta, 1'b0);
    chk1("rst_doutb", doutb, 1'b0);
    chk1("rst_dout_en", dout_en, 1'b0);
    chk1("rst_viol", viol, 1'b0);

    convst = 1'b1;
    step(1);
    chk1("stby_cv_viol", viol, 1'b1);
    chk1("stby_cv_busy", busy, 1'b0);
    convst = 1'b0;
    step(1);
    chk1("stby_viol_clr", viol, 1'b0);

    // Wake: early convst rejected, later one accepted
    stby = 1'b1;
    step(30);
    convst = 1'b1;
    step(1);
    chk1("wake_cv_viol", viol, 1'b1);
    chk1("wake_cv_busy", busy, 1'b0);
    convst = 1'b0;
    step(40);
    convst = 1'b1;
    step(1);
    chk1("conv1_busy_on", busy, 1'b1);
    chk1("conv1_viol", viol, 1'b0);
    convst = 1'b0;
    step(119);
    chk1("conv1_busy_last", busy, 1'b1);
    step(1);
    chk1("conv1_busy_off", busy, 1'b0);

    // First read: count 0 results
    read_frame(rd_a, rd_b, rd_f);
    chk64("rd1_a", rd_a, 64'h0000_0001_0002_0003);
    chk64("rd1_b", rd_b, 64'h0004_0005_0006_0007);
    chk64("rd1_frst", rd_f, 64'hFFFF_0000_0000_0000);
    chk1("rd1_viol", viol, 1'b0);
    end_frame();

    // Second conversion and read
    do_conv();
    read_frame(rd_a, rd_b, rd_f);
    chk64("rd2_a", rd_a, 64'h0008_0009_000A_000B);
    chk64("rd2_b", rd_b, 64'h000C_000D_000E_000F);
    end_frame();

    // Third conversion: retrigger rejected, read during CONV returns prior words
    convst = 1'b1;
    step(1);
    convst = 1'b0;
    step(2);
    chk1("conv3_busy", busy, 1'b1);
    convst = 1'b1;
    step(1);
    chk1("conv_cv_viol", viol, 1'b1);
    chk1("conv_cv_busy", busy, 1'b1);
    convst = 1'b0;
    step(1);
    read_frame(rd_a, rd_b, rd_f);
    chk64("rd3_a", rd_a, 64'h0008_0009_000A_000B);
    chk64("rd3_b", rd_b, 64'h000C_000D_000E_000F);
    chk1("rd3_busy_done", busy, 1'b0);
    end_frame();
    read_frame(rd_a, rd_b, rd_f);
    chk64("rd4_a", rd_a, 64'h0010_0011_0012_0013);
    end_frame();

    // Abort at busy cycle 50, re-wake: aborted conversion not counted
    convst = 1'b1;
    step(1);
    convst = 1'b0;
    chk1("conv4_busy", busy, 1'b1);
    step(49);
    chk1("conv4_busy50", busy, 1'b1);
    stby = 1'b0;
    step(1);
    chk1("abort_busy", busy, 1'b0);
    stby = 1'b1;
    step(65);
    do_conv();
    read_frame(rd_a, rd_b, rd_f);
    chk64("rd5_a", rd_a, 64'h0018_0019_001A_001B);
    chk64("rd5_b", rd_b, 64'h001C_001D_001E_001F);
    end_frame();

    // stby drop and convst rise together: standby wins, flagged
    stby   = 1'b0;
    convst = 1'b1;
    step(1);
    chk1("race_viol", viol, 1'b1);
    chk1("race_busy", busy, 1'b0);
    convst = 1'b0;
    step(2);

    // cs_n fall in standby flagged; then reset mid-read
    cs_n = 1'b0;
    step(1);
    chk1("stby_cs_viol", viol, 1'b1);
    step(2);
    chk1("mid_dout_en", dout_en, 1'b1);
    chk1("mid_frst", frstdata, 1'b1);
    sclk = 1'b0;
    step(3);
    chk1("mid_sclk_noviol", viol, 1'b0);
    sclk = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    chk1("mrst_dout_en", dout_en, 1'b0);
    chk1("mrst_frst", frstdata, 1'b0);
    chk1("mrst_douta", douta, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_viol", viol, 1'b0);
    cs_n = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    // sclk edges with cs_n high: one viol per edge, lines stay quiet
    sclk = 1'b0;
    step(1);
    chk1("hi_fall_viol", viol, 1'b1);
    chk1("hi_douta", douta, 1'b0);
    chk1("hi_dout_en", dout_en, 1'b0);
    step(1);
    chk1("hi_viol_clr", viol, 1'b0);
    sclk = 1'b1;
    step(1);
    chk1("hi_rise_viol", viol, 1'b1);
    step(1);

    // conv_cnt and results were cleared by reset
    stby = 1'b1;
    step(65);
    do_conv();
    read_frame(rd_a, rd_b, rd_f);
    chk64("rd6_a", rd_a, 64'h0000_0001_0002_0003);
    chk64("rd6_b", rd_b, 64'h0004_0005_0006_0007);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
